// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for uart_rx and uart_tx.
//   - uart_state_e  : 3-bit FSM state encoding (IDLE/START/DATA/PARITY/STOP/CLEANUP)
//   - CLK_CNT_W     : width of the per-bit clock counter
//   - CLKS_PER_BIT_DEF : default i_Clock cycles per bit
package uart_pkg;

  localparam int unsigned CLK_CNT_W        = 12;
  localparam int unsigned CLKS_PER_BIT_DEF = 434;
  localparam int unsigned DATA_W           = 8;
  localparam int unsigned BIT_IDX_W        = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and received-byte/status outputs of uart_rx.
//   master : receiver side (samples i_Rx_Serial, drives byte, DV, active, errors)
//   slave  : line driver / consumer side
interface uart_rx_if;
  import uart_pkg::*;

  logic              i_Rx_Serial;
  logic              o_Rx_DV;
  logic [DATA_W-1:0] o_Rx_Byte;
  logic              o_Rx_Active;
  logic              o_Rx_Frame_Err;
  logic              o_Rx_Parity_Err;

  modport master (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Active,
    output o_Rx_Frame_Err,
    output o_Rx_Parity_Err
  );

  modport slave (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Active,
    input  o_Rx_Frame_Err,
    input  o_Rx_Parity_Err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the asynchronous RX pin.
//   i_Clock   : system clock
//   i_Reset   : synchronous active-high reset
//   async_in  : raw serial line
//   sync_out  : synchronized line
// Resets to 1 (line idle level) so reset never looks like a start edge.
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;

  always_ff @(posedge i_Clock) begin : sync_reg
    if (i_Reset) begin
      meta_q   <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8 data bits LSB first, 1 start, 1 stop, optional parity.
//   i_Clock  : system clock (rising edge)
//   i_Reset  : synchronous active-high reset
//   rx       : uart_rx_if.master (i_Rx_Serial in; o_Rx_DV, o_Rx_Byte,
//              o_Rx_Active, o_Rx_Frame_Err, o_Rx_Parity_Err out)
// Build option: define UART_RX_PARITY_EN to add one parity bit after bit 7
// (sense set by PARITY_ODD). Undefined: no parity bit, o_Rx_Parity_Err = 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  uart_rx_if.master rx
);

  localparam logic [CLK_CNT_W-1:0] HALF_CNT = CLK_CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CLK_CNT_W-1:0] FULL_CNT = CLK_CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e          state_q, state_d;
  logic [CLK_CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic [DATA_W-1:0]    byte_q, byte_d;
  logic                 parity_bad_q, parity_bad_d;
  logic                 armed_q, armed_d;
  logic                 dv_q, dv_d;
  logic                 active_q, active_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_s;
  logic                 half_done;
  logic                 bit_done;

  uart_rx_sync u_sync (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .async_in (rx.i_Rx_Serial),
    .sync_out (rx_s)
  );

  assign half_done = (clk_cnt_q == HALF_CNT);
  assign bit_done  = (clk_cnt_q == FULL_CNT);

  // State register
  always_ff @(posedge i_Clock) begin : state_reg
    if (i_Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin : state_next
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s && armed_q) state_d = START;
      START:   if (half_done) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (bit_done && (bit_idx_q == BIT_IDX_W'(DATA_W - 1))) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY:  if (bit_done) state_d = STOP;
      STOP:    if (bit_done) state_d = CLEANUP;
      CLEANUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
`endif

  always_comb begin : out_next
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    parity_bad_d = parity_bad_q;
    // Any high on the synced line re-arms start detection.
    armed_d      = armed_q | rx_s;
    active_d     = active_q;
    dv_d         = 1'b0;
    ferr_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        clk_cnt_d    = '0;
        bit_idx_d    = '0;
        parity_bad_d = 1'b0;
        if (!rx_s && armed_q) armed_d = 1'b0;
      end
      START: begin
        if (half_done) begin
          clk_cnt_d = '0;
          if (!rx_s) active_d = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + BIT_IDX_W'(1);
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_done) begin
          clk_cnt_d    = '0;
          parity_bad_d = (rx_s != ((^shift_q) ^ PARITY_ODD));
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            ferr_d  = 1'b1;
            // Low stop bit means a break: wait for the line to go high again.
            armed_d = 1'b0;
          end else if (parity_bad_q) begin
`ifdef UART_RX_PARITY_EN
            perr_d = 1'b1;
`endif
          end else begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      CLEANUP: begin
        clk_cnt_d = '0;
        active_d  = 1'b0;
      end
      default: begin
        clk_cnt_d = '0;
        active_d  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_Clock) begin : dp_reg
    if (i_Reset) begin
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_q       <= '0;
      parity_bad_q <= 1'b0;
      armed_q      <= 1'b0;
      active_q     <= 1'b0;
      dv_q         <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      parity_bad_q <= parity_bad_d;
      armed_q      <= armed_d;
      active_q     <= active_d;
      dv_q         <= dv_d;
      ferr_q       <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_Clock) begin : perr_reg
    if (i_Reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign rx.o_Rx_Parity_Err = perr_q;
`else
  assign rx.o_Rx_Parity_Err = 1'b0;
`endif

  assign rx.o_Rx_DV        = dv_q;
  assign rx.o_Rx_Byte      = byte_q;
  assign rx.o_Rx_Active    = active_q;
  assign rx.o_Rx_Frame_Err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CLKS_PER_BIT = 8.
// Directed frames plus a randomized burst checked against a frame-level model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned C     = 8;
  localparam int unsigned HALF  = (C - 1) / 2;
  localparam bit          P_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if rx_bus ();

  uart_rx #(
    .CLKS_PER_BIT (C),
    .PARITY_ODD   (P_ODD)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .rx      (rx_bus)
  );

  int checks = 0;
  int errors = 0;

  // Output monitor, sampled on the falling edge
  int         dv_cnt   = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         act_cnt  = 0;
  int         long_cnt = 0;
  logic       dv_prev  = 1'b0;
  logic       fe_prev  = 1'b0;
  logic       pe_prev  = 1'b0;
  time        dv_time  = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (rx_bus.o_Rx_DV === 1'b1) begin
      dv_cnt <= dv_cnt + 1;
      got_q.push_back(rx_bus.o_Rx_Byte);
      dv_time <= $time;
    end
    if (rx_bus.o_Rx_Frame_Err === 1'b1)  ferr_cnt <= ferr_cnt + 1;
    if (rx_bus.o_Rx_Parity_Err === 1'b1) perr_cnt <= perr_cnt + 1;
    if (rx_bus.o_Rx_Active === 1'b1)     act_cnt  <= act_cnt + 1;
    if ((rx_bus.o_Rx_DV && dv_prev) || (rx_bus.o_Rx_Frame_Err && fe_prev) ||
        (rx_bus.o_Rx_Parity_Err && pe_prev))
      long_cnt <= long_cnt + 1;
    dv_prev <= rx_bus.o_Rx_DV;
    fe_prev <= rx_bus.o_Rx_Frame_Err;
    pe_prev <= rx_bus.o_Rx_Parity_Err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pop_byte();
    if (got_q.size() == 0) return 8'hxx;
    return got_q.pop_front();
  endfunction

`ifdef UART_RX_PARITY_EN
  // Correct parity bit: XOR of the data, inverted for odd parity.
  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ P_ODD;
  endfunction

  task automatic send_frame_par(input logic [7:0] d, input logic par);
    rx_bus.i_Rx_Serial = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 8; i++) begin
      rx_bus.i_Rx_Serial = d[i];
      wait_cycles(C);
    end
    rx_bus.i_Rx_Serial = par;
    wait_cycles(C);
    rx_bus.i_Rx_Serial = 1'b1;
    wait_cycles(C);
  endtask
`endif

  // Start bit, 8 data bits LSB first, [parity], stop bit; line left at stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_bus.i_Rx_Serial = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 8; i++) begin
      rx_bus.i_Rx_Serial = d[i];
      wait_cycles(C);
    end
`ifdef UART_RX_PARITY_EN
    rx_bus.i_Rx_Serial = good_par(d);
    wait_cycles(C);
`endif
    rx_bus.i_Rx_Serial = stop;
    wait_cycles(C);
  endtask

  int         dv0, fe0, pe0, act0, gap;
  time        td;
  logic [7:0] d;
  logic [7:0] exp_q[$];

  initial begin
    rx_bus.i_Rx_Serial = 1'b1;

    // Reset state
    rst = 1'b1;
    wait_cycles(3);
    check("rst_dv",     32'(rx_bus.o_Rx_DV),         32'd0);
    check("rst_byte",   32'(rx_bus.o_Rx_Byte),       32'd0);
    check("rst_active", 32'(rx_bus.o_Rx_Active),     32'd0);
    check("rst_ferr",   32'(rx_bus.o_Rx_Frame_Err),  32'd0);
    check("rst_perr",   32'(rx_bus.o_Rx_Parity_Err), 32'd0);
    check("rst_state",  32'(dut.state_q),            32'(IDLE));
    rst = 1'b0;
    wait_cycles(2 * C);

    // Single frame 0x55 with latency
    dv0 = dv_cnt; fe0 = ferr_cnt;
    td  = $time;
    send_frame(8'h55, 1'b1);
    wait_cycles(C);
    check("f55_dv_count", 32'(dv_cnt - dv0),  32'd1);
    check("f55_ferr",     32'(ferr_cnt - fe0), 32'd0);
    check("f55_byte",     32'(pop_byte()),     32'h55);
    check("f55_out_byte", 32'(rx_bus.o_Rx_Byte), 32'h55);
    check("f55_latency",  32'(dv_time - td),
          32'(4 + 10 * (4 + HALF + (FRAME_BITS - 1) * C)));
    check("f55_pulse_width", 32'(long_cnt), 32'd0);

    // Back-to-back frames, no idle gap
    dv0 = dv_cnt;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    wait_cycles(C);
    check("b2b_dv_count", 32'(dv_cnt - dv0), 32'd2);
    check("b2b_byte0",    32'(pop_byte()),   32'hA5);
    check("b2b_byte1",    32'(pop_byte()),   32'h3C);

    // Two-cycle low glitch while idle
    dv0 = dv_cnt; act0 = act_cnt;
    rx_bus.i_Rx_Serial = 1'b0;
    wait_cycles(2);
    rx_bus.i_Rx_Serial = 1'b1;
    wait_cycles(3 * C);
    check("glitch_active", 32'(act_cnt - act0), 32'd0);
    check("glitch_dv",     32'(dv_cnt - dv0),   32'd0);
    check("glitch_state",  32'(dut.state_q),    32'(IDLE));

    // Frame error on 0xFF, then line held low
    dv0 = dv_cnt; fe0 = ferr_cnt; pe0 = perr_cnt;
    send_frame(8'hFF, 1'b0);
    wait_cycles(4);
    act0 = act_cnt;
    wait_cycles(100);
    check("ferr_count",     32'(ferr_cnt - fe0),  32'd1);
    check("ferr_no_dv",     32'(dv_cnt - dv0),    32'd0);
    check("ferr_no_perr",   32'(perr_cnt - pe0),  32'd0);
    check("ferr_byte_held", 32'(rx_bus.o_Rx_Byte), 32'h3C);
    check("break_active",   32'(act_cnt - act0),  32'd0);
    check("break_state",    32'(dut.state_q),     32'(IDLE));
    rx_bus.i_Rx_Serial = 1'b1;
    wait_cycles(2 * C);
    dv0 = dv_cnt;
    send_frame(8'h5A, 1'b1);
    wait_cycles(C);
    check("recover_dv",   32'(dv_cnt - dv0), 32'd1);
    check("recover_byte", 32'(pop_byte()),   32'h5A);

    // Reset in the middle of data bit 4 of 0x81
    d = 8'h81;
    dv0 = dv_cnt; fe0 = ferr_cnt;
    rx_bus.i_Rx_Serial = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 4; i++) begin
      rx_bus.i_Rx_Serial = d[i];
      wait_cycles(C);
    end
    rx_bus.i_Rx_Serial = d[4];
    wait_cycles(C / 2);
    check("midrst_active_before", 32'(rx_bus.o_Rx_Active), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_bus.i_Rx_Serial = 1'b1;
    check("midrst_dv",     32'(rx_bus.o_Rx_DV),         32'd0);
    check("midrst_byte",   32'(rx_bus.o_Rx_Byte),       32'd0);
    check("midrst_active", 32'(rx_bus.o_Rx_Active),     32'd0);
    check("midrst_ferr",   32'(rx_bus.o_Rx_Frame_Err),  32'd0);
    check("midrst_perr",   32'(rx_bus.o_Rx_Parity_Err), 32'd0);
    check("midrst_state",  32'(dut.state_q),            32'(IDLE));
    wait_cycles(3 * C);
    check("midrst_no_dv",   32'(dv_cnt - dv0),   32'd0);
    check("midrst_no_ferr", 32'(ferr_cnt - fe0), 32'd0);
    dv0 = dv_cnt;
    send_frame(8'h12, 1'b1);
    wait_cycles(C);
    check("after_rst_dv",   32'(dv_cnt - dv0), 32'd1);
    check("after_rst_byte", 32'(pop_byte()),   32'h12);

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 has odd weight, so even parity needs a 1
    dv0 = dv_cnt; pe0 = perr_cnt;
    send_frame_par(8'h07, 1'b1);
    wait_cycles(C);
    check("par_ok_dv",   32'(dv_cnt - dv0),   32'd1);
    check("par_ok_byte", 32'(pop_byte()),     32'h07);
    check("par_ok_perr", 32'(perr_cnt - pe0), 32'd0);
    dv0 = dv_cnt; pe0 = perr_cnt; fe0 = ferr_cnt;
    send_frame_par(8'h07, 1'b0);
    wait_cycles(C);
    check("par_bad_perr", 32'(perr_cnt - pe0), 32'd1);
    check("par_bad_dv",   32'(dv_cnt - dv0),   32'd0);
    check("par_bad_ferr", 32'(ferr_cnt - fe0), 32'd0);
`endif

    // Randomized burst with random idle gaps (including none)
    dv0 = dv_cnt; fe0 = ferr_cnt;
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send_frame(d, 1'b1);
      gap = int'($urandom_range(0, 2 * C));
      if (gap > 0) wait_cycles(gap);
    end
    wait_cycles(2 * C);
    check("rand_dv_count", 32'(dv_cnt - dv0),   32'(exp_q.size()));
    check("rand_ferr",     32'(ferr_cnt - fe0), 32'd0);
    while (exp_q.size() > 0) begin
      check("rand_byte", 32'(pop_byte()), 32'(exp_q.pop_front()));
    end

    check("pulse_width_all", 32'(long_cnt), 32'd0);
`ifdef UART_RX_PARITY_EN
    check("perr_total", 32'(perr_cnt), 32'd1);
`else
    check("perr_total", 32'(perr_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
